// File: rtl/tx_buffer.sv
// tx_buffer: byte FIFO sitting directly in front of the UART sender.
// The core pushes bytes at full clock rate. An issue FSM hands them to the
// sender one frame at a time over the sender's ready/done handshake.
// Optional build macro TX_BUFFER_OVERFLOW_EN: when defined, `overflow` is a
// sticky flag set by any dropped push. When undefined, `overflow` is tied to 0.
// Dropped pushes behave the same way in both builds.
module tx_buffer #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic [7:0]            as,
    output logic                  ready,
    input  logic                  done,
    output logic                  busy,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] COUNT_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};

    // IDLE issues when data is waiting and the sender is idle.
    // ISSUE holds the one-cycle ready pulse.
    // WAIT_LOW waits for the sender to start its frame.
    // WAIT_HIGH waits for the frame to end.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_LOW  = 2'd2,
        WAIT_HIGH = 2'd3
    } state_t;

    // Storage and pointers
    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_q, wr_d;
    logic [DEPTH_LOG2-1:0] rd_q, rd_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;

    // Issue FSM and sender-facing registers
    state_t                state_q, state_d;
    logic                  ready_q, ready_d;
    logic [7:0]            as_q, as_d;

    logic                  push_en;
    logic                  pop_en;

    // Full is taken from the pre-edge count. A push in the same cycle as an
    // issue pop from a full buffer is therefore still dropped.
    assign full    = (count_q == COUNT_MAX);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign as      = as_q;
    assign ready   = ready_q;
    assign busy    = (state_q != IDLE) || (count_q != '0);
    assign push_en = in_valid && !full;

    // Issue FSM: next state, ready pulse, and the byte presented to the sender
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_d = state_q;
        ready_d = 1'b0;
        as_d    = as_q;
        pop_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Waiting for done=1 also keeps a frame left running across a
                // reset from being overlapped by the next one.
                if ((count_q != '0) && done) begin
                    pop_en  = 1'b1;
                    ready_d = 1'b1;
                    as_d    = mem_q[rd_q];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // The sender latches `as` on this edge, and ready drops again.
                state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!done) begin
                    state_d = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pointer and occupancy next-state. Pointers wrap through natural overflow.
    always_comb begin
        wr_d    = push_en ? wr_q + DEPTH_LOG2'(1) : wr_q;
        rd_d    = pop_en  ? rd_q + DEPTH_LOG2'(1) : rd_q;
        count_d = count_q;
        unique case ({push_en, pop_en})
            2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state registers, with synchronous reset taking priority
    always_ff @(posedge CLK) begin
        // NOTE: state is updated with non-blocking assignments. All registers
        // then sample pre-edge values, whatever the order of the statements.
        if (RST) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            state_q <= IDLE;
            ready_q <= 1'b0;
            as_q    <= 8'h00;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            state_q <= state_d;
            ready_q <= ready_d;
            as_q    <= as_d;
        end
    end

    // Byte storage write port
    always_ff @(posedge CLK) begin
        // NOTE: the storage array has no reset. Reset clears count and the
        // pointers, so stale entries can never be read, and the array can map
        // onto plain RAM.
        if (!RST && push_en) begin
            mem_q[wr_q] <= in_data;
        end
    end

`ifdef TX_BUFFER_OVERFLOW_EN
    logic ovf_q;

    // Sticky drop flag: set by a push into a full buffer, cleared only by reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            ovf_q <= 1'b0;
        end else if (in_valid && full) begin
            ovf_q <= 1'b1;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

endmodule
